dmem_ctrl: RTL and testbench

//  Data-memory responder for the downsampling processor's MEM/address/data interface.

---
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the downsampling processor.
// Single-port byte RAM with a 1-cycle registered read. The processor port always has
// priority; a host port preloads and dumps the RAM while the processor is idle.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN. When it is defined, addresses >= DEPTH
// set a sticky err flag, writes to them are dropped and reads from them return 0.
// When it is undefined, the address wraps modulo DEPTH and err is always 0.
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 65536
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [1:0]        MEM,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              proc_active,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRD  = 2'd1;
    localparam logic [1:0] HRD  = 2'd2;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              proc_rd;
    logic              proc_wr;
    logic              host_acc;
    logic              host_rd;
    logic              host_wr;
    logic              proc_oob;
    logic              host_oob;
    logic              err_set;
    logic              ram_we;
    logic [IDX_W-1:0]  proc_idx;
    logic [IDX_W-1:0]  host_idx;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    assign proc_idx = addr[IDX_W-1:0];
    assign host_idx = host_addr[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    // Out-of-range detection on both ports
    assign proc_oob = {1'b0, addr} >= DEPTH_LIM;
    assign host_oob = {1'b0, host_addr} >= DEPTH_LIM;
`else
    logic unused_addr_bits;

    // No range check: high address bits simply alias onto the RAM
    assign proc_oob         = 1'b0;
    assign host_oob         = 1'b0;
    assign unused_addr_bits = ^{addr, host_addr};
`endif

    // FSM state register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and access decode; processor requests win over the host
    always_comb begin
        state_nxt = state;
        proc_rd   = 1'b0;
        proc_wr   = 1'b0;
        host_acc  = 1'b0;
        host_rd   = 1'b0;
        host_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (MEM == OP_READ) begin
                    proc_rd   = 1'b1;
                    state_nxt = PRD;
                end else if (MEM == OP_WRITE) begin
                    proc_wr = 1'b1;
                end else if (MEM == OP_NONE && host_valid && !proc_active) begin
                    host_acc = 1'b1;
                    if (host_we) begin
                        host_wr = 1'b1;
                    end else begin
                        host_rd   = 1'b1;
                        state_nxt = HRD;
                    end
                end
            end
            PRD:     state_nxt = IDLE;
            HRD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign host_ready = host_acc && !RST;
    assign err_set    = ((proc_rd || proc_wr) && proc_oob) || (host_acc && host_oob);
    assign ram_we     = !RST && ((proc_wr && !proc_oob) || (host_wr && !host_oob));
    assign ram_idx    = proc_wr ? proc_idx : host_idx;
    assign ram_wdata  = proc_wr ? wdata : host_wdata;

    // RAM array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
    end

    // Registered read data, host read strobe and sticky error flag
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rdata       <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            err         <= 1'b0;
        end else begin
            host_rvalid <= host_rd;
            err         <= err | err_set;
            if (proc_rd) begin
                rdata <= proc_oob ? '0 : mem[proc_idx];
            end
            if (host_rd) begin
                host_rdata <= host_oob ? '0 : mem[host_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: drivers push expected read data, a monitor checks it.
module tb_dmem_ctrl;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 65536;

    logic              clk;
    logic              RST;
    logic [1:0]        MEM;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              proc_active;
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              err;

    dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .RST(RST), .MEM(MEM), .addr(addr), .wdata(wdata), .rdata(rdata),
        .proc_active(proc_active), .host_valid(host_valid), .host_ready(host_ready),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .err(err)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       hq[$];
    exp_t       pq[$];
    logic [7:0] ref_mem [int];
    int         wr_list[$];
    bit         ref_err = 0;
    bit         have_last = 0;
    logic [7:0] last_rd = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference memory: byte array indexed by address modulo DEPTH
    function automatic bit is_oob(input int a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return a >= int'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void m_write(input int a, input logic [7:0] d);
        if (is_oob(a)) begin
            ref_err = 1'b1;
        end else begin
            ref_mem[a % int'(DEPTH)] = d;
            wr_list.push_back(a);
        end
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (is_oob(a)) begin
            ref_err = 1'b1;
            return 8'h00;
        end
        if (ref_mem.exists(a % int'(DEPTH))) return ref_mem[a % int'(DEPTH)];
        return 8'hxx;
    endfunction

    // Monitor: pops expected read results when due, checks held data and err
    always @(negedge clk) begin
        if (!RST) begin
            if (hq.size() != 0 && hq[0].due <= cyc) begin
                chk("host_rvalid", 32'(host_rvalid), 32'd1);
                chk("host_rdata", 32'(host_rdata), 32'(hq[0].val));
                void'(hq.pop_front());
            end else begin
                chk("host_rvalid_idle", 32'(host_rvalid), 32'd0);
            end
            if (pq.size() != 0 && pq[0].due <= cyc) begin
                chk("proc_rdata", 32'(rdata), 32'(pq[0].val));
                last_rd   = pq[0].val;
                have_last = 1'b1;
                void'(pq.pop_front());
            end else if (have_last) begin
                chk("proc_rdata_hold", 32'(rdata), 32'(last_rd));
            end
            chk("err", 32'(err), 32'(ref_err));
        end
    end

    task automatic proc_write(input int a, input logic [7:0] d);
        proc_active = 1'b1;
        MEM = 2'b01; addr = ADDR_W'(a); wdata = d;
        @(posedge clk); #1;
        m_write(a, d);
        MEM = 2'b00;
    endtask

    task automatic proc_read(input int a);
        exp_t e;
        proc_active = 1'b1;
        MEM = 2'b10; addr = ADDR_W'(a);
        @(posedge clk); #1;
        e.due = cyc; e.val = m_read(a);
        pq.push_back(e);
        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    task automatic proc_reserved(input int a, input logic [7:0] d);
        MEM = 2'b11; addr = ADDR_W'(a); wdata = d;
        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    // Host request; optionally held off by proc_active for some cycles first
    task automatic host_op(input bit we, input int a, input logic [7:0] d, input int stall);
        exp_t e;
        bit   got = 1'b0;
        MEM = 2'b00;
        host_valid = 1'b1; host_we = we; host_addr = ADDR_W'(a); host_wdata = d;
        proc_active = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("host_ready_stall", 32'(host_ready), 32'd0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            proc_active = 1'b0;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (host_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("host_ready_timeout", 32'(host_ready), 32'd1);
            host_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        host_valid = 1'b0;
        if (we) begin
            m_write(a, d);
        end else begin
            e.due = cyc; e.val = m_read(a);
            hq.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_t e;
        int   a;
        RST = 1'b1; MEM = 2'b00; addr = '0; wdata = '0; proc_active = 1'b0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        #2;
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;

        // Host preload, then back-to-back reads of the same byte
        host_op(1'b1, 'h10, 8'hA5, 0);
        host_valid = 1'b1; host_we = 1'b0; host_addr = ADDR_W'('h10);
        @(negedge clk); chk("b2b_ready_first", 32'(host_ready), 32'd1);
        @(posedge clk); #1;
        e.due = cyc; e.val = 8'hA5; hq.push_back(e);
        @(negedge clk); chk("b2b_ready_stall", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b_ready_second", 32'(host_ready), 32'd1);
        @(posedge clk); #1;
        e.due = cyc; e.val = 8'hA5; hq.push_back(e);
        host_valid = 1'b0;
        @(posedge clk); #1;

        // Processor write then read, data held while idle
        proc_write('h20, 8'h3C);
        proc_read('h20);
        repeat (3) begin
            @(negedge clk); chk("proc_rdata_held", 32'(rdata), 32'h3C);
        end
        @(posedge clk); #1;

        // Arbitration: processor read and active status block the host write
        proc_active = 1'b1; MEM = 2'b10; addr = ADDR_W'('h20);
        host_valid = 1'b1; host_we = 1'b1; host_addr = ADDR_W'('h30); host_wdata = 8'h99;
        @(negedge clk); chk("arb_ready_memrd", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        e.due = cyc; e.val = 8'h3C; pq.push_back(e);
        @(negedge clk); chk("arb_ready_prd", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        MEM = 2'b00;
        @(negedge clk); chk("arb_ready_active", 32'(host_ready), 32'd0);
        host_op(1'b1, 'h30, 8'h99, 0);
        host_op(1'b0, 'h30, 8'h00, 0);
        proc_read('h20);

        // Address beyond DEPTH: aliases when unchecked, flagged when checked
        host_op(1'b1, 'h00005, 8'h11, 0);
        host_op(1'b1, 'h10005, 8'h7E, 0);
        @(negedge clk);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("bounds_err", 32'(err), 32'd1);
`else
        chk("bounds_err", 32'(err), 32'd0);
`endif
        @(posedge clk); #1;
        host_op(1'b0, 'h10005, 8'h00, 0);
        host_op(1'b0, 'h00005, 8'h00, 0);

        // Randomized mix of processor and host traffic
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 4));
            if (op == 0 || op == 2) begin
                a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, (1 << ADDR_W) - 1));
                if (op == 0) proc_write(a, 8'($urandom));
                else host_op(1'b1, a, 8'($urandom), int'($urandom_range(0, 2)));
            end else if (op == 4) begin
                proc_reserved(int'($urandom_range(0, 255)), 8'($urandom));
            end else begin
                a = wr_list[$urandom_range(0, wr_list.size() - 1)] % int'(DEPTH);
                a = a + int'(DEPTH) * int'($urandom_range(0, 7));
                if (op == 1) proc_read(a);
                else host_op(1'b0, a, 8'h00, int'($urandom_range(0, 2)));
            end
        end

        // Asynchronous reset during a host read data phase
        a = wr_list[0];
        host_valid = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(a); proc_active = 1'b0;
        @(negedge clk); chk("rstmid_ready", 32'(host_ready), 32'd1);
        @(posedge clk); #2;
        RST = 1'b1;
        hq.delete(); pq.delete(); have_last = 1'b0; ref_err = 1'b0;
        #1;
        chk("rstmid_rvalid", 32'(host_rvalid), 32'd0);
        chk("rstmid_rdata", 32'(rdata), 32'd0);
        chk("rstmid_host_rdata", 32'(host_rdata), 32'd0);
        chk("rstmid_host_ready", 32'(host_ready), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        host_valid = 1'b0;
        @(posedge clk); #1;
        RST = 1'b0;
        host_op(1'b0, a, 8'h00, 0);
        proc_read(a);

        repeat (4) @(posedge clk);
        chk("host_queue_drained", 32'(hq.size()), 32'd0);
        chk("proc_queue_drained", 32'(pq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
